// File: rtl/test_monitor_pkg.sv
// test_monitor_pkg
// Shared definitions for the riscv-tests result monitor: the 3-bit FSM state
// encoding, default register indices for test-case / done / pass, the default
// settle delay and a helper that classifies terminal states.
package test_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_PASS    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  localparam int DEF_CASE_REG      = 3;
  localparam int DEF_DONE_REG      = 26;
  localparam int DEF_PASS_REG      = 27;
  localparam int DEF_SETTLE_CYCLES = 2;

  function automatic logic is_terminal(state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/test_monitor_shadow.sv
// test_monitor_shadow
// Shadow copies of the test-case, done and pass registers, built by snooping
// the register-file writeback port. Writes to x0 are dropped.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clr          synchronous clear of all shadows
//   upd_en       shadows accept writes only while high
//   wb_en/addr/data  writeback snoop
//   case_nxt, done_nxt, pass_nxt  shadow values including a same-cycle write
//   done_wr      accepted write to the done register this cycle (any value)
module test_monitor_shadow
  import test_monitor_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CASE_REG = DEF_CASE_REG,
  parameter int DONE_REG = DEF_DONE_REG,
  parameter int PASS_REG = DEF_PASS_REG
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            upd_en,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] case_nxt,
  output logic [XLEN-1:0] done_nxt,
  output logic [XLEN-1:0] pass_nxt,
  output logic            done_wr
);

  logic [XLEN-1:0] case_q, done_q, pass_q;
  logic            wr_ok;
  logic            hit_case, hit_done, hit_pass;

  assign wr_ok    = wb_en && upd_en && (wb_addr != 5'd0);
  assign hit_case = wr_ok && (wb_addr == 5'(CASE_REG));
  assign hit_done = wr_ok && (wb_addr == 5'(DONE_REG));
  assign hit_pass = wr_ok && (wb_addr == 5'(PASS_REG));

  // The forwarded values double as the register next-state, so the decision
  // logic sees exactly what the shadows will hold after this edge.
  assign case_nxt = hit_case ? wb_data : case_q;
  assign done_nxt = hit_done ? wb_data : done_q;
  assign pass_nxt = hit_pass ? wb_data : pass_q;
  assign done_wr  = hit_done;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      case_q <= '0;
      done_q <= '0;
      pass_q <= '0;
    end else begin
      case_q <= case_nxt;
      done_q <= done_nxt;
      pass_q <= pass_nxt;
    end
  end

endmodule

// File: rtl/test_monitor.sv
// test_monitor
// riscv-tests result checker. Watches writeback to the case/done/pass
// registers and decides PASS, FAIL or TIMEOUT after a settle delay, with a
// RUN-state cycle watchdog.
//
//   state      | meaning
//   IDLE   (0) | waiting for enable
//   RUN    (1) | test executing, watchdog armed
//   SETTLE (2) | done seen, waiting before sampling the pass register
//   PASS   (3) | verdict pass (sticky)
//   FAIL   (4) | verdict fail (sticky)
//   TIMEOUT(5) | watchdog expired in RUN (sticky)
//
// Ports: clk, rst_n (sync active-low), enable, clr, wb_en/wb_addr/wb_data
// (writeback snoop); outputs done, pass, fail, timeout, fail_case, cycle_cnt,
// state -- all registered.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int CASE_REG      = DEF_CASE_REG,
  parameter int DONE_REG      = DEF_DONE_REG,
  parameter int PASS_REG      = DEF_PASS_REG,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT       = 100000,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [XLEN-1:0]  fail_case,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [2:0]       state
);

  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] WDOG_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  fail_case_q, fail_case_d;
  logic             done_q, pass_q, fail_q, timeout_q;

  logic [XLEN-1:0]  case_nxt, done_nxt, pass_nxt;
  logic             done_wr;
  logic             done_acc;
  state_e           verdict;

  test_monitor_shadow #(
    .XLEN    (XLEN),
    .CASE_REG(CASE_REG),
    .DONE_REG(DONE_REG),
    .PASS_REG(PASS_REG)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .upd_en  (!is_terminal(state_q)),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .case_nxt(case_nxt),
    .done_nxt(done_nxt),
    .pass_nxt(pass_nxt),
    .done_wr (done_wr)
  );

  assign done_acc = (state_q == ST_RUN) && done_wr && (done_nxt == XLEN'(1));
  assign verdict  = (pass_nxt == XLEN'(1)) ? ST_PASS : ST_FAIL;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    cnt_d       = cnt_q;
    fail_case_d = fail_case_q;

    if (((state_q == ST_RUN) || (state_q == ST_SETTLE)) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A done write beats a watchdog expiry in the same cycle.
        if (done_acc) begin
          if (SETTLE_CYCLES == 0) begin
            state_d = verdict;
          end else begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_LOAD;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == WDOG_LAST)) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = verdict;
        else                settle_d = settle_q - 1'b1;
      end
      default: ;
    endcase

    if (is_terminal(state_d) && !is_terminal(state_q)) begin
      fail_case_d = case_nxt;
    end

    if (clr) begin
      state_d     = ST_IDLE;
      settle_d    = '0;
      cnt_d       = '0;
      fail_case_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      cnt_q       <= '0;
      fail_case_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      fail_case_q <= fail_case_d;
      done_q      <= is_terminal(state_d);
      pass_q      <= (state_d == ST_PASS);
      fail_q      <= (state_d == ST_FAIL);
      timeout_q   <= (state_d == ST_TIMEOUT);
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign fail_case = fail_case_q;
  assign cycle_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: doc/test_monitor.md
# test_monitor

Synthesizable riscv-tests result checker. It snoops the core's register-file writeback port and tracks the test-number, done and pass registers. It decides PASS, FAIL or TIMEOUT with a configurable settle delay and a cycle watchdog. It sits beside `core_inst` inside `soc`, replacing hierarchical register peeking in benches and allowing on-board self-test.

## Interface
Parameters:
- `XLEN`, 32, data width of writeback bus and shadow registers
- `CASE_REG`, 3, register index holding current test case number
- `DONE_REG`, 26, register index whose write of value 1 signals end of test
- `PASS_REG`, 27, register index whose value 1 at decision time means pass
- `SETTLE_CYCLES`, 2, cycles between done detection and decision (0 allowed)
- `TIMEOUT`, 100000, max cycles in RUN before TIMEOUT; 0 disables watchdog
- `CNT_W`, 32, width of cycle counter

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `enable`  in  1  level; IDLE→RUN when high
- `clr`  in  1  synchronous restart to IDLE, clears shadows and counters
- `wb_en`  in  1  register writeback valid
- `wb_addr`  in  5  writeback register index
- `wb_data`  in  XLEN  writeback data
- `done`  out  1  high in PASS, FAIL or TIMEOUT
- `pass`  out  1  high in PASS
- `fail`  out  1  high in FAIL
- `timeout`  out  1  high in TIMEOUT
- `fail_case`  out  XLEN  CASE_REG shadow frozen at decision
- `cycle_cnt`  out  CNT_W  cycles spent in RUN+SETTLE
- `state`  out  3  current FSM state encoding

## Operation
- States: IDLE(0), RUN(1), SETTLE(2), PASS(3), FAIL(4), TIMEOUT(5).
- Shadows: on `wb_en` with `wb_addr`≠0, shadow of matching index (CASE/DONE/PASS) takes `wb_data`. Writes to x0 are ignored. Shadows update in every state except terminal ones.
- IDLE→RUN when `enable`=1. RUN ignores `enable` afterwards.
- RUN→SETTLE on an accepted write of exactly 1 to DONE_REG. Other values update the shadow only. With SETTLE_CYCLES=0 the decision is taken directly from RUN on that edge.
- SETTLE: down-counter loaded with SETTLE_CYCLES−1. Further DONE writes are ignored. On expiry → PASS if the effective PASS value equals 1, else FAIL.
  - The effective PASS value is the shadow, forwarded with a same-cycle PASS_REG write.
- `fail_case` is captured on the decision edge (forwarded likewise). It is held in all terminal states and also captured on TIMEOUT.
- Watchdog: in RUN, when TIMEOUT≠0 and `cycle_cnt`=TIMEOUT−1 and no done write this cycle → TIMEOUT. A done write in the same cycle wins.
- `cycle_cnt` increments in RUN and SETTLE, saturates at all-ones, and freezes in terminal states.
- Terminal states are sticky until `clr` or reset.
- `clr` has priority over all transitions. `rst_n`=0 has priority over `clr`.

## Timing
- All outputs are registered. Reset/clr values: state IDLE; done, pass, fail, timeout all 0; fail_case 0; cycle_cnt 0; all shadows 0.
- The DONE write is accepted at edge T. The SETTLE state is visible after T. The decision outputs are visible after edge T+SETTLE_CYCLES.
- A PASS_REG write at any edge ≤ T+SETTLE_CYCLES affects the verdict.
- The IDLE→RUN edge does not count a cycle. The first RUN cycle gives `cycle_cnt`=1 after the next edge.
- Reset or clr mid-SETTLE aborts the test with no verdict. Outputs return to reset values on that edge.

## Structure
- `test_monitor_pkg`: state enum (3-bit), default register indices, shared default of SETTLE_CYCLES.
- Sub-module `test_monitor_shadow`: the three shadow registers, x0 filter, and forwarded next-value outputs.
- The FSM, settle counter and watchdog live in the top.

## Test plan
- Write x3=5, x27=1, then x26=1 → after 2 edges: pass=1, done=1, fail_case=5, state=3.
- Write x27=0, x3=7, x26=1 → fail=1, fail_case=7, pass=0.
- x26=1 at edge T, x27=1 at edge T+2 (SETTLE_CYCLES=2) → pass=1. The same write at T+3 → fail=1, and the post-decision write is ignored.
- TIMEOUT=20, no x26 write → timeout=1 with cycle_cnt=20. Repeat with x26=1 exactly at cycle 20 → SETTLE, no timeout.
- x26 written with 2, then writes to x0 with 1 → stays in RUN. A later x26=1 → SETTLE.
- `clr` pulsed in SETTLE and `rst_n`=0 in PASS → state 0 and all outputs 0 on the next edge. Re-run with `enable` yields a fresh verdict.
